// File: rtl/d_latch_reader_pkg.sv
// Shared definitions for the D latch reader: FSM state width and encodings.
package d_latch_reader_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_SETTLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/d_latch_reader_sync_bit.sv
// Single-bit synchroniser: STAGES flops in series, all cleared by the
// asynchronous active-low reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/d_latch_reader.sv
// Clocked reader/checker for a level-sensitive D latch.
// Synchronises the latch enable and output, counts data toggles while the
// latch is transparent, captures the held value once the latch has stayed
// closed for SETTLE_CYC cycles, and flags output changes during hold.
// Optional macro HOLD_ERR_STICKY_EN: when defined, o_hold_err is sticky
// until i_clr or reset; otherwise it pulses once per hold-phase toggle cycle.
module d_latch_reader #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 2,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_q,
    input  logic             i_clr,
    output logic             o_valid,
    output logic             o_hold_val,
    output logic [CNT_W-1:0] o_toggle_cnt,
    output logic [CNT_W-1:0] o_window_cnt,
    output logic             o_hold_err,
    output logic [1:0]       o_state
);

    import d_latch_reader_pkg::*;

    // Settle counter only needs to hold SETTLE_CYC-1.
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic en_s;
    logic q_s;
    logic en_d_reg;
    logic q_d_reg;
    logic rise;
    logic fall;
    logic toggle;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   win_cnt_reg;
    logic [CNT_W-1:0]   win_cnt_next;
    logic [SET_W-1:0]   settle_cnt_reg;
    logic [SET_W-1:0]   settle_cnt_next;
    logic               capture;
    logic               hold_toggle;

    logic               valid_reg;
    logic               hold_val_reg;
    logic [CNT_W-1:0]   toggle_cnt_reg;
    logic [CNT_W-1:0]   window_cnt_reg;
    logic               hold_err_reg;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_enable),
        .q     (en_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_q (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_q),
        .q     (q_s)
    );

    // One-cycle history of the synchronised signals for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en_d_reg <= 1'b0;
            q_d_reg  <= 1'b0;
        end else begin
            en_d_reg <= en_s;
            q_d_reg  <= q_s;
        end
    end

    assign rise        = en_s & ~en_d_reg;
    assign fall        = ~en_s & en_d_reg;
    assign toggle      = q_s ^ q_d_reg;
    assign hold_toggle = (state_reg == S_HOLD) & toggle;

    // FSM state, per-window toggle count and settle countdown.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= S_IDLE;
            win_cnt_reg    <= '0;
            settle_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            win_cnt_reg    <= win_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
        end
    end

    // Next-state logic; a rise during SETTLE is a glitch, so the window
    // resumes with its toggle count intact and nothing is captured.
    always_comb begin
        state_next      = state_reg;
        win_cnt_next    = win_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        capture         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (rise) begin
                    state_next   = S_OPEN;
                    win_cnt_next = '0;
                end
            end
            S_OPEN: begin
                if (toggle && (win_cnt_reg != CNT_MAX)) begin
                    win_cnt_next = win_cnt_reg + CNT_W'(1);
                end
                if (fall) begin
                    state_next      = S_SETTLE;
                    settle_cnt_next = SET_W'(SETTLE_CYC - 1);
                end
            end
            S_SETTLE: begin
                if (rise) begin
                    state_next = S_OPEN;
                end else if (settle_cnt_reg == '0) begin
                    state_next = S_HOLD;
                    capture    = 1'b1;
                end else begin
                    settle_cnt_next = settle_cnt_reg - SET_W'(1);
                end
            end
            S_HOLD: begin
                if (rise) begin
                    state_next   = S_OPEN;
                    win_cnt_next = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Capture results; a coincident clear zeroes the counters but the
    // valid pulse and held value still update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_reg      <= 1'b0;
            hold_val_reg   <= 1'b0;
            toggle_cnt_reg <= '0;
            window_cnt_reg <= '0;
        end else begin
            valid_reg <= capture;
            if (capture) begin
                hold_val_reg <= q_s;
            end
            if (i_clr) begin
                toggle_cnt_reg <= '0;
                window_cnt_reg <= '0;
            end else if (capture) begin
                toggle_cnt_reg <= win_cnt_reg;
                window_cnt_reg <= window_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Hold-phase output change detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_err_reg <= 1'b0;
        end else begin
`ifdef HOLD_ERR_STICKY_EN
            if (i_clr) begin
                hold_err_reg <= 1'b0;
            end else if (hold_toggle) begin
                hold_err_reg <= 1'b1;
            end
`else
            hold_err_reg <= hold_toggle & ~i_clr;
`endif
        end
    end

    assign o_valid      = valid_reg;
    assign o_hold_val   = hold_val_reg;
    assign o_toggle_cnt = toggle_cnt_reg;
    assign o_window_cnt = window_cnt_reg;
    assign o_hold_err   = hold_err_reg;
    assign o_state      = state_reg;

endmodule

// File: tb/tb_d_latch_reader.sv
// Self-checking bench for d_latch_reader: directed scenarios plus randomized
// windows checked against a window-level model (toggles per window, value at
// close, completed-window count, hold-phase changes).
module tb_d_latch_reader;

    localparam int SYNC_STAGES = 2;
    localparam int SETTLE_CYC  = 2;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    // Steps from driving enable low until o_valid is seen high.
    localparam int EXP_LAT     = SYNC_STAGES + SETTLE_CYC + 1;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_enable = 1'b0;
    logic             i_q = 1'b0;
    logic             i_clr = 1'b0;
    logic             o_valid;
    logic             o_hold_val;
    logic [CNT_W-1:0] o_toggle_cnt;
    logic [CNT_W-1:0] o_window_cnt;
    logic             o_hold_err;
    logic [1:0]       o_state;

    int checks = 0;
    int failures = 0;
    int model_windows = 0;
    int valid_total = 0;
    int herr_cycles = 0;
    int herr_rises = 0;
    bit herr_prev = 1'b0;
    bit exp_sticky = 1'b0;

    d_latch_reader #(
        .SYNC_STAGES (SYNC_STAGES),
        .SETTLE_CYC  (SETTLE_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .i_q          (i_q),
        .i_clr        (i_clr),
        .o_valid      (o_valid),
        .o_hold_val   (o_hold_val),
        .o_toggle_cnt (o_toggle_cnt),
        .o_window_cnt (o_window_cnt),
        .o_hold_err   (o_hold_err),
        .o_state      (o_state)
    );

    always #5 i_clk = ~i_clk;

    // Event counters sampled mid-cycle; comparisons happen in the tests.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid === 1'b1) valid_total++;
            if (o_hold_err === 1'b1) begin
                herr_cycles++;
                if (!herr_prev) herr_rises++;
            end
            herr_prev = (o_hold_err === 1'b1);
        end else begin
            herr_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (o_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic drive_window(input int len, input int pct, output int tog);
        tog = 0;
        i_enable = 1'b1;
        step();
        step();
        for (int c = 0; c < len; c++) begin
            if (int'($urandom_range(99)) < pct) begin
                i_q = ~i_q;
                tog++;
            end
            step();
        end
        step();
        i_enable = 1'b0;
    endtask

    task automatic test_reset();
        bit found;
        int lat;
        i_rst_n = 1'b0; i_enable = 1'b1; i_q = 1'b1; i_clr = 1'b0;
        repeat (3) step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_hold_val !== 1'b0) begin failures++; $display("FAIL reset_hold_val: got %b expected 0", o_hold_val); end
        checks++; if (o_toggle_cnt !== '0) begin failures++; $display("FAIL reset_toggle_cnt: got %0d expected 0", o_toggle_cnt); end
        checks++; if (o_window_cnt !== '0) begin failures++; $display("FAIL reset_window_cnt: got %0d expected 0", o_window_cnt); end
        checks++; if (o_hold_err !== 1'b0) begin failures++; $display("FAIL reset_hold_err: got %b expected 0", o_hold_err); end
        checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", o_state); end
        i_rst_n = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            if (o_state === 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin failures++; $display("FAIL reset_open: got state %0d expected 1 within 3 cycles", o_state); end
        // One toggle inside this window, then close it with q=0.
        i_q = 1'b0;
        step(); step();
        i_enable = 1'b0;
        wait_valid(lat);
        model_windows = 1;
        checks++; if (lat !== EXP_LAT) begin failures++; $display("FAIL reset_win_latency: got %0d expected %0d", lat, EXP_LAT); end
        checks++; if (o_hold_val !== 1'b0) begin failures++; $display("FAIL reset_win_hold_val: got %b expected 0", o_hold_val); end
        checks++; if (o_toggle_cnt !== CNT_W'(1)) begin failures++; $display("FAIL reset_win_toggles: got %0d expected 1", o_toggle_cnt); end
        checks++; if (o_window_cnt !== CNT_W'(model_windows)) begin failures++; $display("FAIL reset_win_count: got %0d expected %0d", o_window_cnt, model_windows); end
        step();
    endtask

    task automatic test_basic();
        int lat;
        int v0;
        int h0;
        v0 = valid_total;
        h0 = herr_cycles;
        i_enable = 1'b1;
        repeat (6) begin
            #15 i_q = ~i_q;
        end
        #10 i_enable = 1'b0;
        wait_valid(lat);
        model_windows++;
        checks++; if (lat !== EXP_LAT) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", lat, EXP_LAT); end
        checks++; if (o_hold_val !== 1'b0) begin failures++; $display("FAIL basic_hold_val: got %b expected 0", o_hold_val); end
        checks++; if (o_toggle_cnt !== CNT_W'(6)) begin failures++; $display("FAIL basic_toggles: got %0d expected 6", o_toggle_cnt); end
        checks++; if (o_window_cnt !== CNT_W'(model_windows)) begin failures++; $display("FAIL basic_window_cnt: got %0d expected %0d", o_window_cnt, model_windows); end
        step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_width: got %b expected 0", o_valid); end
        checks++; if (valid_total !== v0 + 1) begin failures++; $display("FAIL basic_valid_count: got %0d expected %0d", valid_total - v0, 1); end
        checks++; if (herr_cycles !== h0) begin failures++; $display("FAIL basic_no_hold_err: got %0d expected 0", herr_cycles - h0); end
    endtask

    task automatic test_saturation();
        int lat;
        i_enable = 1'b1;
        step(); step();
        repeat (300) begin
            i_q = ~i_q;
            step();
        end
        step();
        i_enable = 1'b0;
        wait_valid(lat);
        model_windows++;
        checks++; if (lat !== EXP_LAT) begin failures++; $display("FAIL sat_latency: got %0d expected %0d", lat, EXP_LAT); end
        checks++; if (o_toggle_cnt !== CNT_W'(CNT_MAX)) begin failures++; $display("FAIL sat_toggles: got %0d expected %0d", o_toggle_cnt, CNT_MAX); end
        checks++; if (o_hold_val !== 1'b0) begin failures++; $display("FAIL sat_hold_val: got %b expected 0", o_hold_val); end
        step();
    endtask

    task automatic test_abort();
        int lat;
        int v0;
        v0 = valid_total;
        i_enable = 1'b1;
        step(); step();
        repeat (3) begin i_q = ~i_q; step(); step(); end
        step();
        i_enable = 1'b0;
        step();
        i_enable = 1'b1;
        step(); step(); step();
        repeat (4) begin i_q = ~i_q; step(); step(); end
        step();
        i_enable = 1'b0;
        wait_valid(lat);
        model_windows++;
        checks++; if (lat !== EXP_LAT) begin failures++; $display("FAIL abort_latency: got %0d expected %0d", lat, EXP_LAT); end
        checks++; if (o_toggle_cnt !== CNT_W'(7)) begin failures++; $display("FAIL abort_toggles: got %0d expected 7", o_toggle_cnt); end
        checks++; if (o_hold_val !== 1'b1) begin failures++; $display("FAIL abort_hold_val: got %b expected 1", o_hold_val); end
        checks++; if (o_window_cnt !== CNT_W'(model_windows)) begin failures++; $display("FAIL abort_window_cnt: got %0d expected %0d", o_window_cnt, model_windows); end
        step();
        checks++; if (valid_total !== v0 + 1) begin failures++; $display("FAIL abort_valid_count: got %0d expected 1", valid_total - v0); end
    endtask

    task automatic test_hold_err();
        int h0;
        int r0;
        h0 = herr_cycles;
        r0 = herr_rises;
        i_q = ~i_q;
        repeat (5) step();
        i_q = ~i_q;
        repeat (6) step();
`ifdef HOLD_ERR_STICKY_EN
        checks++; if (o_hold_err !== 1'b1) begin failures++; $display("FAIL herr_sticky_set: got %b expected 1", o_hold_err); end
        repeat (3) step();
        checks++; if (o_hold_err !== 1'b1) begin failures++; $display("FAIL herr_sticky_stays: got %b expected 1", o_hold_err); end
`else
        checks++; if (herr_cycles - h0 !== 2) begin failures++; $display("FAIL herr_pulse_cycles: got %0d expected 2", herr_cycles - h0); end
        checks++; if (herr_rises - r0 !== 2) begin failures++; $display("FAIL herr_pulse_count: got %0d expected 2", herr_rises - r0); end
`endif
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        step();
        model_windows = 0;
        exp_sticky = 1'b0;
        checks++; if (o_hold_err !== 1'b0) begin failures++; $display("FAIL clr_hold_err: got %b expected 0", o_hold_err); end
        checks++; if (o_window_cnt !== '0) begin failures++; $display("FAIL clr_window_cnt: got %0d expected 0", o_window_cnt); end
        checks++; if (o_toggle_cnt !== '0) begin failures++; $display("FAIL clr_toggle_cnt: got %0d expected 0", o_toggle_cnt); end
        checks++; if (o_state !== 2'd3) begin failures++; $display("FAIL clr_keeps_state: got %0d expected 3", o_state); end
    endtask

    task automatic test_clear_on_capture();
        logic exp_val;
        i_enable = 1'b1;
        step(); step();
        i_q = ~i_q;
        exp_val = i_q;
        step(); step();
        i_enable = 1'b0;
        repeat (EXP_LAT - 1) step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL coc_early_valid: got %b expected 0", o_valid); end
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        model_windows = 0;
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL coc_valid: got %b expected 1", o_valid); end
        checks++; if (o_hold_val !== exp_val) begin failures++; $display("FAIL coc_hold_val: got %b expected %b", o_hold_val, exp_val); end
        checks++; if (o_window_cnt !== '0) begin failures++; $display("FAIL coc_window_cnt: got %0d expected 0", o_window_cnt); end
        checks++; if (o_toggle_cnt !== '0) begin failures++; $display("FAIL coc_toggle_cnt: got %0d expected 0", o_toggle_cnt); end
        step();
    endtask

    task automatic test_random();
        int len;
        int tog;
        int lat;
        int nh;
        int h0;
        int exp_tog;
        for (int w = 0; w < 20; w++) begin
            len = int'($urandom_range(3, 30));
            drive_window(len, 50, tog);
            wait_valid(lat);
            model_windows = (model_windows + 1) % (CNT_MAX + 1);
            exp_tog = (tog > CNT_MAX) ? CNT_MAX : tog;
            checks++; if (lat !== EXP_LAT) begin failures++; $display("FAIL rnd%0d_latency: got %0d expected %0d", w, lat, EXP_LAT); end
            checks++; if (o_hold_val !== i_q) begin failures++; $display("FAIL rnd%0d_hold_val: got %b expected %b", w, o_hold_val, i_q); end
            checks++; if (o_toggle_cnt !== CNT_W'(exp_tog)) begin failures++; $display("FAIL rnd%0d_toggles: got %0d expected %0d", w, o_toggle_cnt, exp_tog); end
            checks++; if (o_window_cnt !== CNT_W'(model_windows)) begin failures++; $display("FAIL rnd%0d_window_cnt: got %0d expected %0d", w, o_window_cnt, model_windows); end
            nh = int'($urandom_range(0, 3));
            h0 = herr_cycles;
            for (int k = 0; k < nh; k++) begin
                i_q = ~i_q;
                repeat (2 + int'($urandom_range(3))) step();
            end
            repeat (6) step();
`ifdef HOLD_ERR_STICKY_EN
            if (nh > 0) exp_sticky = 1'b1;
            checks++; if (o_hold_err !== exp_sticky) begin failures++; $display("FAIL rnd%0d_hold_err: got %b expected %b", w, o_hold_err, exp_sticky); end
`else
            checks++; if (herr_cycles - h0 !== nh) begin failures++; $display("FAIL rnd%0d_hold_err: got %0d expected %0d", w, herr_cycles - h0, nh); end
`endif
        end
    endtask

    task automatic test_reset_mid_window();
        int v0;
        i_enable = 1'b1;
        step(); step();
        repeat (3) begin i_q = ~i_q; step(); end
        #3 i_rst_n = 1'b0;
        #1;
        checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL midrst_state: got %0d expected 0", o_state); end
        checks++; if (o_window_cnt !== '0) begin failures++; $display("FAIL midrst_window_cnt: got %0d expected 0", o_window_cnt); end
        checks++; if (o_hold_val !== 1'b0) begin failures++; $display("FAIL midrst_hold_val: got %b expected 0", o_hold_val); end
        i_enable = 1'b0;
        step(); step();
        i_rst_n = 1'b1;
        v0 = valid_total;
        repeat (15) step();
        checks++; if (valid_total !== v0) begin failures++; $display("FAIL midrst_no_valid: got %0d expected 0", valid_total - v0); end
        checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL midrst_idle: got %0d expected 0", o_state); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_abort();
        test_hold_err();
        test_clear_on_capture();
        test_random();
        test_reset_mid_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
